key_operand_loader: RTL and testbench

KEY_OPERAND_LOADER -- requirements
Module: key_operand_loader

---
 rtl/key_operand_loader_pkg.sv | 13 +
 rtl/key_operand_loader_key_debounce.sv | 56 +++++
 rtl/key_operand_loader.sv | 92 +++++++++
 tb/tb_key_operand_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/key_operand_loader_pkg.sv
// Shared types and defaults for the two-key operand loader.
package key_operand_loader_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int OPERAND_W           = 5;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    READY  = 2'd2
  } state_e;

endpackage

// File: rtl/key_operand_loader_key_debounce.sv
// One pushbutton: 2-flop synchronizer, stable-level debouncer, press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    // Counter only runs while the synced level disagrees; agreement restarts it.
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/key_operand_loader.sv
// Captures operands A then B from switches on debounced LOAD presses and
// offers the pair downstream with a valid/ready handshake; CLEAR restarts.
module key_operand_loader
  import key_operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int W               = OPERAND_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   key_n,
  input  logic [W-1:0] sw,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         op_valid,
  input  logic         op_ready,
  output logic [1:0]   state
);

  logic [1:0] press;

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n[k]),
      .press (press[k])
    );
  end

  logic         load_p, clear_p, xfer;
  logic [W-1:0] sw_q, sw_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  state_e       state_q, state_d;

  assign load_p  = press[0];
  assign clear_p = press[1];
  assign xfer    = (state_q == READY) && op_ready;

  always_comb begin
    sw_d    = sw;
    a_d     = a_q;
    b_d     = b_q;
    state_d = state_q;
    if (clear_p) begin
      a_d     = '0;
      b_d     = '0;
      state_d = LOAD_A;
    end else begin
      case (state_q)
        LOAD_A: if (load_p) begin
          a_d     = sw_q;
          state_d = LOAD_B;
        end
        LOAD_B: if (load_p) begin
          b_d     = sw_q;
          state_d = READY;
        end
        // A new LOAD restarts the pair whether or not a transfer also happens.
        READY: begin
          if (load_p) begin
            a_d     = sw_q;
            state_d = LOAD_B;
          end else if (xfer) begin
            state_d = LOAD_A;
          end
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      state_q <= LOAD_A;
    end else begin
      sw_q    <= sw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      state_q <= state_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign op_valid = (state_q == READY);
  assign state    = state_q;

endmodule

// File: tb/tb_key_operand_loader.sv
// Randomized + directed bench for key_operand_loader against a queue-based reference model.
module tb_key_operand_loader;

  localparam int DB = 4;
  localparam int W  = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   key_n;
  logic [W-1:0] sw;
  logic [W-1:0] a, b;
  logic         op_valid, op_ready;
  logic [1:0]   state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_operand_loader #(.DEBOUNCE_CYCLES(DB), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_n),
    .sw       (sw),
    .a        (a),
    .b        (b),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .state    (state)
  );

  // Reference model: raw key history in a 2-deep queue, run lengths of
  // disagreeing samples, and the operand-pair rules applied per edge.
  logic [1:0]   dq[$];
  logic [1:0]   stab, pend, v;
  int           run[2];
  logic [W-1:0] m_a, m_b, m_sw;
  int           m_st;
  logic         lp, cp;

  always @(posedge clk) begin
    if (rst) begin
      dq = {};
      dq.push_back(2'b11);
      dq.push_back(2'b11);
      stab = 2'b11; pend = 2'b00; run[0] = 0; run[1] = 0;
      m_a = '0; m_b = '0; m_sw = '0; m_st = 0;
    end else begin
      lp = pend[0];
      cp = pend[1];
      v  = dq.pop_front();
      dq.push_back(key_n);
      for (int k = 0; k < 2; k++) begin
        pend[k] = 1'b0;
        if (v[k] != stab[k]) begin
          run[k]++;
          if (run[k] == DB) begin
            stab[k] = v[k];
            run[k]  = 0;
            pend[k] = (v[k] == 1'b0);
          end
        end else begin
          run[k] = 0;
        end
      end
      if (cp) begin
        m_a = '0; m_b = '0; m_st = 0;
      end else if (lp) begin
        if (m_st == 1) begin
          m_b = m_sw; m_st = 2;
        end else begin
          m_a = m_sw; m_st = 1;
        end
      end else if (m_st == 2 && op_ready) begin
        m_st = 0;
      end
      m_sw = sw;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("a", 32'(a), 32'(m_a));
      chk("b", 32'(b), 32'(m_b));
      chk("state", 32'(state), 32'(m_st));
      chk("op_valid", 32'(op_valid), 32'(m_st == 2));
    end
  endtask

  task automatic tap(input logic [1:0] keys);
    key_n = ~keys;
    cyc(10);
    key_n = 2'b11;
    cyc(8);
  endtask

  initial begin
    rst = 1'b1; key_n = 2'b11; sw = '0; op_ready = 1'b0;
    cyc(3);
    rst = 1'b0;

    // idle after reset
    cyc(100);
    chk("idle_a", 32'(a), 32'h0);
    chk("idle_b", 32'(b), 32'h0);
    chk("idle_valid", 32'(op_valid), 32'h0);
    chk("idle_state", 32'(state), 32'h0);

    // load A then B, hold with op_ready low
    sw = 5'h13; tap(2'b01);
    chk("ldA_state", 32'(state), 32'h1);
    sw = 5'h07; tap(2'b01);
    cyc(20);
    chk("pair_a", 32'(a), 32'h13);
    chk("pair_b", 32'(b), 32'h07);
    chk("pair_valid", 32'(op_valid), 32'h1);
    chk("pair_state", 32'(state), 32'h2);

    // single-cycle transfer
    op_ready = 1'b1; cyc(1); op_ready = 1'b0;
    chk("xfer_valid", 32'(op_valid), 32'h0);
    chk("xfer_state", 32'(state), 32'h0);
    chk("xfer_a", 32'(a), 32'h13);
    chk("xfer_b", 32'(b), 32'h07);

    // op_ready outside READY is ignored
    op_ready = 1'b1; sw = 5'h0a; tap(2'b01); op_ready = 1'b0;
    chk("ign_ready_state", 32'(state), 32'h1);
    chk("ign_ready_a", 32'(a), 32'h0a);

    // LOAD and CLEAR together in LOAD_B
    tap(2'b11);
    chk("clr_a", 32'(a), 32'h0);
    chk("clr_b", 32'(b), 32'h0);
    chk("clr_state", 32'(state), 32'h0);

    // bouncing LOAD
    sw = 5'h15;
    repeat (5) begin
      key_n[0] = 1'b0; cyc(3);
      key_n[0] = 1'b1; cyc(1);
    end
    chk("bounce_none", 32'(state), 32'h0);
    key_n[0] = 1'b0; cyc(6);
    chk("bounce_early", 32'(state), 32'h0);
    cyc(1);
    chk("bounce_a", 32'(a), 32'h15);
    chk("bounce_state", 32'(state), 32'h1);
    cyc(10); key_n[0] = 1'b1; cyc(8);
    chk("bounce_once", 32'(state), 32'h1);

    // reset mid-debounce with key held
    sw = 5'h1a; key_n[0] = 1'b0; cyc(4);
    rst = 1'b1; cyc(2);
    chk("rst_a", 32'(a), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    rst = 1'b0; cyc(6);
    chk("rst_hold_state", 32'(state), 32'h0);
    cyc(1);
    chk("rst_cap_a", 32'(a), 32'h1a);
    chk("rst_cap_state", 32'(state), 32'h1);
    key_n[0] = 1'b1; cyc(8);

    // random phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0)  key_n[0] = ~key_n[0];
      if ($urandom_range(11) == 0) key_n[1] = ~key_n[1];
      sw       = W'($urandom);
      op_ready = ($urandom_range(3) == 0);
      rst      = ($urandom_range(499) == 0);
      cyc(1);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
